// File: rtl/vending_machine.sv
// Single-product vending FSM: price 15, accepts one 5 or 10 coin per clock,
// with registered dispense pulse and refund code.
module vending_machine (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] in,
  output logic       out,
  output logic [1:0] change
);

  typedef enum logic [1:0] {
    S0  = 2'd0,
    S5  = 2'd1,
    S10 = 2'd2
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;

  state_t     state, state_nx;
  logic       out_nx;
  logic [1:0] change_nx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S0;
      out    <= 1'b0;
      change <= 2'b00;
    end else begin
      state  <= state_nx;
      out    <= out_nx;
      change <= change_nx;
    end
  end

  // Code 11 falls through every inner case: state held, no pulse, no refund.
  always_comb begin
    state_nx  = state;
    out_nx    = 1'b0;
    change_nx = 2'b00;
    case (state)
      S0: begin
        case (in)
          COIN_5:  state_nx = S5;
          COIN_10: state_nx = S10;
          default: ;
        endcase
      end
      S5: begin
        case (in)
          COIN_NONE: begin state_nx = S0; change_nx = 2'b01; end
          COIN_5:    state_nx = S10;
          COIN_10:   begin state_nx = S0; out_nx = 1'b1; end
          default: ;
        endcase
      end
      S10: begin
        case (in)
          COIN_NONE: begin state_nx = S0; change_nx = 2'b10; end
          COIN_5:    begin state_nx = S0; out_nx = 1'b1; end
          COIN_10:   begin state_nx = S0; out_nx = 1'b1; change_nx = 2'b01; end
          default: ;
        endcase
      end
      default: state_nx = S0;
    endcase
  end

endmodule

// File: tb/tb_vending_machine.sv
// Scoreboard bench for vending_machine: a credit-arithmetic model pushes the
// expected {out,change} per edge; each test pops and compares after the edge.
module tb_vending_machine;

  logic       clk;
  logic       rst;
  logic [1:0] in;
  logic       out;
  logic [1:0] change;

  int n_cmp = 0;
  int n_err = 0;
  int credit = 0;
  logic [2:0] sb[$];

  vending_machine dut (
    .clk    (clk),
    .rst    (rst),
    .in     (in),
    .out    (out),
    .change (change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model works in rupees: credit accumulates, any total >= 15 sells and
  // returns the excess; a cancel returns whatever credit is held.
  task automatic apply(input logic r, input logic [1:0] c);
    int tot;
    logic [2:0] e;
    rst = r;
    in  = c;
    e   = 3'b000;
    if (!r) begin
      credit = 0;
    end else if (c == 2'b00) begin
      e[1:0] = 2'(credit / 5);
      credit = 0;
    end else if (c != 2'b11) begin
      tot = credit + ((c == 2'b01) ? 5 : 10);
      if (tot >= 15) begin
        e      = {1'b1, 2'((tot - 15) / 5)};
        credit = 0;
      end else begin
        credit = tot;
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] e;
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, 2'b01);
      e = sb.pop_front();
      n_cmp++;
      if ({out, change} !== e) begin
        n_err++;
        $display("FAIL reset[%0d] got %b want %b", i, {out, change}, e);
      end
    end
  endtask

  task automatic test_hold_5();
    logic [2:0] e;
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 2'b01);
      e = sb.pop_front();
      n_cmp++;
      if ({out, change} !== e) begin
        n_err++;
        $display("FAIL hold5[%0d] got %b want %b", i, {out, change}, e);
      end
    end
  endtask

  task automatic test_ten_ten();
    logic [2:0] e;
    logic [1:0] seq[4] = '{2'b00, 2'b10, 2'b10, 2'b00};
    for (int i = 0; i < 4; i++) begin
      apply((i == 0) ? 1'b0 : 1'b1, seq[i]);
      e = sb.pop_front();
      n_cmp++;
      if ({out, change} !== e) begin
        n_err++;
        $display("FAIL ten_ten[%0d] got %b want %b", i, {out, change}, e);
      end
    end
  endtask

  task automatic test_cancel();
    logic [2:0] e;
    logic [1:0] seq[5] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b00};
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, seq[i]);
      e = sb.pop_front();
      n_cmp++;
      if ({out, change} !== e) begin
        n_err++;
        $display("FAIL cancel[%0d] got %b want %b", i, {out, change}, e);
      end
    end
  endtask

  task automatic test_ignored();
    logic [2:0] e;
    logic [1:0] seq[6] = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b10, 2'b00};
    for (int i = 0; i < 6; i++) begin
      apply(1'b1, seq[i]);
      e = sb.pop_front();
      n_cmp++;
      if ({out, change} !== e) begin
        n_err++;
        $display("FAIL ignored[%0d] got %b want %b", i, {out, change}, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] e;
    logic       rs[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0] seq[5] = '{2'b10, 2'b00, 2'b10, 2'b11, 2'b00};
    for (int i = 0; i < 5; i++) begin
      apply(rs[i], seq[i]);
      e = sb.pop_front();
      n_cmp++;
      if ({out, change} !== e) begin
        n_err++;
        $display("FAIL reset_mid[%0d] got %b want %b", i, {out, change}, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] e;
    logic       r;
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 19) != 0);
      apply(r, 2'($urandom_range(0, 3)));
      e = sb.pop_front();
      n_cmp++;
      if ({out, change} !== e) begin
        n_err++;
        $display("FAIL b2b[%0d] got %b want %b", i, {out, change}, e);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    in  = 2'b00;
    test_reset();
    test_hold_5();
    test_ten_ten();
    test_cancel();
    test_ignored();
    test_reset_mid();
    test_back_to_back();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain got %0d want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
